// File: rtl/systolic_pkg.sv
// Shared types and helpers for the weight-stationary systolic array.
package systolic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoadW,
    StStream,
    StDrain
  } state_e;

  // Default result width: full product plus growth for a ROWS-deep reduction.
  function automatic int acc_w_default(input int data_w, input int rows);
    return 2 * data_w + $clog2(rows);
  endfunction

endpackage

// File: rtl/ws_pe.sv
// Single processing element: stationary weight, multiply-add, registered pass-through.
module ws_pe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 34
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              w_load,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [ACC_W-1:0]  s_in,
  output logic [DATA_W-1:0] a_out,
  output logic [ACC_W-1:0]  s_out
);

  logic [DATA_W-1:0]          w_q;
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           prod_ext;

  assign prod     = $signed(a_in) * $signed(w_q);
  // Signed cast sign-extends the full-precision product to the accumulator width.
  assign prod_ext = ACC_W'(prod);

  // Weight register, written only during weight loading.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q <= '0;
    end else if (w_load) begin
      w_q <= w_in;
    end
  end

  // Activation moves right, partial sum moves down; both stall with the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_out <= '0;
      s_out <= '0;
    end else if (en) begin
      a_out <= a_in;
      s_out <= s_in + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_array_ws.sv
// Weight-stationary systolic array computing Y[t][c] = sum_r A[t][r] * W[r][c].
module systolic_array_ws
  import systolic_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = acc_w_default(DATA_W, ROWS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [COLS-1:0][DATA_W-1:0] w_row,
  input  logic                        w_last,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic [ROWS-1:0][DATA_W-1:0] a_vec,
  input  logic                        a_last,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic [COLS-1:0][ACC_W-1:0]  y_vec,
  output logic                        y_last,
  output logic                        busy,
  output logic                        err
);

  localparam int CntW  = $clog2(ROWS);
  // Valid/last travel this many stages to line up with the deskewed sums.
  localparam int Depth = ROWS + COLS;
  localparam logic [CntW-1:0] LastBeat = CntW'(ROWS - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              loaded_q, loaded_d;
  logic              err_q, err_d;
  logic [ROWS-1:0]   w_we;
  logic              adv;
  logic              accept;
  logic [Depth-1:0]  vld_q, lst_q;
  logic              y_valid_q, y_last_q;
  logic [COLS-1:0][ACC_W-1:0] y_vec_q;

  logic [DATA_W-1:0] a_h     [ROWS][COLS+1];
  logic [ACC_W-1:0]  s_v     [ROWS+1][COLS];
  logic [ACC_W-1:0]  aligned [COLS];

  assign adv     = !(y_valid_q && !y_ready);
  assign accept  = a_valid && a_ready;
  assign busy    = (state_q != StIdle);
  assign err     = err_q;
  assign y_valid = y_valid_q;
  assign y_last  = y_last_q;
  assign y_vec   = y_vec_q;

  // Control state, beat counter, weights-loaded flag and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    w_ready  = 1'b0;
    a_ready  = 1'b0;
    case (state_q)
      StIdle: begin
        if (w_valid) begin
          state_d = StLoadW;
        end else if (a_valid) begin
          if (loaded_q) state_d = StStream;
          else          err_d   = 1'b1;
        end
      end
      StLoadW: begin
        w_ready = 1'b1;
        if (w_valid) begin
          // The beat count, not w_last, ends loading; a misplaced w_last is flagged.
          if (w_last && (cnt_q != LastBeat)) err_d = 1'b1;
          if (cnt_q == LastBeat) begin
            cnt_d    = '0;
            loaded_d = 1'b1;
            state_d  = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StStream: begin
        a_ready = adv;
        if (a_valid && adv && a_last) state_d = StDrain;
      end
      StDrain: begin
        if (y_valid_q && y_ready && y_last_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Per-row weight write strobes for the current beat.
  always_comb begin
    w_we = '0;
    for (int k = 0; k < ROWS; k++) begin
      w_we[k] = (state_q == StLoadW) && w_valid && (cnt_q == CntW'(k));
    end
  end

  // Valid and last markers riding alongside each accepted vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      lst_q <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[Depth-2:0], accept};
      lst_q <= {lst_q[Depth-2:0], accept && a_last};
    end
  end

  // Input skew: row r sees its activation r cycles after row 0.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [DATA_W-1:0] sk_q [r+1];

    // Skew shift chain of length r+1.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int j = 0; j <= r; j++) sk_q[j] <= '0;
      end else if (adv) begin
        sk_q[0] <= a_vec[r];
        for (int j = 1; j <= r; j++) sk_q[j] <= sk_q[j-1];
      end
    end

    assign a_h[r][0] = sk_q[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_top_sum
    assign s_v[0][c] = '0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      ws_pe #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk   (clk),
        .reset (reset),
        .en    (adv),
        .w_load(w_we[r]),
        .w_in  (w_row[c]),
        .a_in  (a_h[r][c]),
        .s_in  (s_v[r][c]),
        .a_out (a_h[r][c+1]),
        .s_out (s_v[r+1][c])
      );
    end
  end

  // Output deskew: column c finishes c cycles late, so early columns wait.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    if (c == COLS - 1) begin : g_none
      assign aligned[c] = s_v[ROWS][c];
    end else begin : g_chain
      logic [ACC_W-1:0] ds_q [COLS-1-c];

      // Deskew shift chain of length COLS-1-c.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int j = 0; j < COLS - 1 - c; j++) ds_q[j] <= '0;
        end else if (adv) begin
          ds_q[0] <= s_v[ROWS][c];
          for (int j = 1; j < COLS - 1 - c; j++) ds_q[j] <= ds_q[j-1];
        end
      end

      assign aligned[c] = ds_q[COLS-2-c];
    end
  end

  // Result register; holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
      y_vec_q   <= '0;
    end else if (adv) begin
      y_valid_q <= vld_q[Depth-1];
      y_last_q  <= lst_q[Depth-1];
      for (int c = 0; c < COLS; c++) y_vec_q[c] <= aligned[c];
    end
  end

endmodule

// File: tb/tb_systolic_array_ws.sv
// Self-checking bench for systolic_array_ws against a matrix-product reference model.
module tb_systolic_array_ws;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 16;
  localparam int AW = 2 * DW + $clog2(R);

  typedef logic [R-1:0][DW-1:0]         avec_t;
  typedef logic [C-1:0][AW-1:0]         yvec_t;
  typedef logic [R-1:0][C-1:0][DW-1:0]  wmat_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic w_valid = 1'b0, w_last = 1'b0, a_valid = 1'b0, a_last = 1'b0, y_ready = 1'b1;
  logic [C-1:0][DW-1:0] w_row = '0;
  avec_t a_vec = '0;
  logic w_ready, a_ready, y_valid, y_last, busy, err;
  yvec_t y_vec;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  wmat_t cur_w;
  avec_t stim [32];
  yvec_t got [32];
  logic  got_last [32];
  int n_got, acc_edge0, first_edge0, stab_bad, ardy_bad, stall_obs;
  bit load_ok;

  systolic_array_ws #(
    .ROWS  (R),
    .COLS  (C),
    .DATA_W(DW),
    .ACC_W (AW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .w_valid(w_valid),
    .w_ready(w_ready),
    .w_row  (w_row),
    .w_last (w_last),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .a_vec  (a_vec),
    .a_last (a_last),
    .y_valid(y_valid),
    .y_ready(y_ready),
    .y_vec  (y_vec),
    .y_last (y_last),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: plain integer matrix-vector product, wrapped to AW bits.
  function automatic yvec_t model_y(input wmat_t w, input avec_t a);
    yvec_t  y;
    longint acc;
    for (int c = 0; c < C; c++) begin
      acc = 0;
      for (int r = 0; r < R; r++) acc += longint'($signed(a[r])) * longint'($signed(w[r][c]));
      y[c] = acc[AW-1:0];
    end
    return y;
  endfunction

  function automatic wmat_t rand_w();
    wmat_t w;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) w[r][c] = DW'($urandom);
    return w;
  endfunction

  function automatic avec_t rand_a();
    avec_t a;
    for (int r = 0; r < R; r++) a[r] = DW'($urandom);
    return a;
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    w_valid = 0; w_last = 0; a_valid = 0; a_last = 0; y_ready = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load_weights(input wmat_t w, input int last_beat);
    int k, cyc;
    k = 0; cyc = 0;
    cur_w = w;
    w_valid = 1'b1;
    while (k < R && cyc < 50) begin
      w_row  = w[k];
      w_last = (k == last_beat);
      @(negedge clk);
      if (w_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
    load_ok = (k == R);
    @(posedge clk); #1;
  endtask

  // Streams stim[0..n-1]; gathers results and backpressure observations into globals.
  task automatic run_job(input int n, input bit bubbles, input int stall_at, input int stall_len);
    n_got = 0; stab_bad = 0; ardy_bad = 0; stall_obs = 0; acc_edge0 = -1; first_edge0 = -1;
    fork
      begin : drive
        int i, cyc;
        i = 0; cyc = 0;
        while (i < n && cyc < 500) begin
          a_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
          a_vec   = stim[i];
          a_last  = (i == n - 1);
          @(negedge clk);
          if (a_valid && a_ready) begin
            if (i == 0) acc_edge0 = cyc_cnt + 1;
            i++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        a_valid = 1'b0;
        a_last  = 1'b0;
      end
      begin : collect
        int k, cyc, stall_left;
        bit stalled, was_held;
        yvec_t held_v;
        logic held_l;
        k = 0; cyc = 0; stall_left = 0; stalled = 0; was_held = 0;
        held_v = '0; held_l = 1'b0;
        while (k < n && cyc < 500) begin
          if (!stalled && stall_len > 0 && k == stall_at && y_valid) begin
            stalled    = 1;
            stall_left = stall_len;
          end
          y_ready = (stall_left == 0);
          @(negedge clk);
          if (y_valid && k == 0 && first_edge0 < 0) first_edge0 = cyc_cnt;
          if (y_valid && !y_ready) begin
            stall_obs++;
            if (a_ready) ardy_bad++;
            if (was_held && (y_vec !== held_v || y_last !== held_l)) stab_bad++;
            held_v   = y_vec;
            held_l   = y_last;
            was_held = 1;
          end else begin
            was_held = 0;
          end
          if (y_valid && y_ready) begin
            got[k]      = y_vec;
            got_last[k] = y_last;
            k++;
          end
          @(posedge clk); #1;
          cyc++;
          if (stall_left > 0) stall_left--;
        end
        y_ready = 1'b1;
        n_got   = k;
      end
    join
  endtask

  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (y_valid) seen++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    w_valid = 1; a_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL rst_w_ready: got %b want 0", w_ready); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready: got %b want 0", a_ready); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rst_y_valid: got %b want 0", y_valid); end
    checks++; if (y_vec !== '0) begin errors++; $display("FAIL rst_y_vec: got %h want 0", y_vec); end
    checks++; if (y_last !== 1'b0) begin errors++; $display("FAIL rst_y_last: got %b want 0", y_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    w_valid = 0; a_valid = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b want 0", busy); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL post_rst_y_valid: got %b want 0", y_valid); end
  endtask

  task automatic test_identity();
    wmat_t w;
    yvec_t exp_y;
    int extra;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) w[r][c] = (r == c) ? DW'(1) : DW'(0);
    load_weights(w, R - 1);
    checks++; if (load_ok !== 1'b1) begin errors++; $display("FAIL id_load: got %b want 1", load_ok); end
    for (int r = 0; r < R; r++) stim[0][r] = DW'(r + 1);
    for (int c = 0; c < C; c++) exp_y[c] = AW'(c + 1);
    run_job(1, 0, 0, 0);
    checks++; if (n_got !== 1) begin errors++; $display("FAIL id_count: got %0d want 1", n_got); end
    checks++; if (got[0] !== exp_y) begin errors++; $display("FAIL id_y: got %h want %h", got[0], exp_y); end
    checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL id_last: got %b want 1", got_last[0]); end
    checks++;
    if (first_edge0 - acc_edge0 !== 8) begin
      errors++; $display("FAIL id_latency: got %0d want 8", first_edge0 - acc_edge0);
    end
    count_valid(10, extra);
    checks++; if (extra !== 0) begin errors++; $display("FAIL id_extra: got %0d want 0", extra); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL id_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL id_err: got %b want 0", err); end
  endtask

  task automatic test_back_to_back();
    wmat_t w;
    yvec_t exp_y [3];
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) w[r][c] = DW'(2);
    load_weights(w, R - 1);
    for (int r = 0; r < R; r++) stim[0][r] = DW'(1);
    stim[1] = '0; stim[1][0] = DW'(-1);
    stim[2] = '0; stim[2][0] = DW'(32767); stim[2][1] = DW'(32767);
    for (int c = 0; c < C; c++) begin
      exp_y[0][c] = AW'(8);
      exp_y[1][c] = AW'(-2);
      exp_y[2][c] = AW'(131068);
    end
    run_job(3, 0, 0, 0);
    checks++; if (n_got !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", n_got); end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (got[j] !== exp_y[j]) begin
        errors++; $display("FAIL b2b_y%0d: got %h want %h", j, got[j], exp_y[j]);
      end
      checks++;
      if (got_last[j] !== (j == 2)) begin
        errors++; $display("FAIL b2b_last%0d: got %b want %b", j, got_last[j], j == 2);
      end
    end
  endtask

  task automatic test_backpressure();
    yvec_t exp_y;
    int extra;
    load_weights(rand_w(), R - 1);
    for (int j = 0; j < 16; j++) stim[j] = rand_a();
    run_job(16, 0, 2, 5);
    checks++; if (n_got !== 16) begin errors++; $display("FAIL bp_count: got %0d want 16", n_got); end
    for (int j = 0; j < 16; j++) begin
      exp_y = model_y(cur_w, stim[j]);
      checks++;
      if (got[j] !== exp_y) begin
        errors++; $display("FAIL bp_y%0d: got %h want %h", j, got[j], exp_y);
      end
    end
    checks++; if (got_last[15] !== 1'b1) begin errors++; $display("FAIL bp_last: got %b want 1", got_last[15]); end
    checks++; if (stall_obs !== 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d want 5", stall_obs); end
    checks++; if (stab_bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", stab_bad); end
    checks++; if (ardy_bad !== 0) begin errors++; $display("FAIL bp_a_ready: got %0d high want 0", ardy_bad); end
    count_valid(12, extra);
    checks++; if (extra !== 0) begin errors++; $display("FAIL bp_extra: got %0d want 0", extra); end
  endtask

  task automatic test_bubbles_persist();
    yvec_t exp_y;
    load_weights(rand_w(), R - 1);
    for (int j = 0; j < 10; j++) stim[j] = rand_a();
    run_job(10, 1, 0, 0);
    checks++; if (n_got !== 10) begin errors++; $display("FAIL bub_count: got %0d want 10", n_got); end
    for (int j = 0; j < 10; j++) begin
      exp_y = model_y(cur_w, stim[j]);
      checks++;
      if (got[j] !== exp_y || got_last[j] !== (j == 9)) begin
        errors++; $display("FAIL bub_y%0d: got %h/%b want %h/%b", j, got[j], got_last[j], exp_y, j == 9);
      end
    end
    // Second job reuses the stationary weights without a reload.
    for (int j = 0; j < 6; j++) stim[j] = rand_a();
    run_job(6, 0, 0, 0);
    checks++; if (n_got !== 6) begin errors++; $display("FAIL persist_count: got %0d want 6", n_got); end
    for (int j = 0; j < 6; j++) begin
      exp_y = model_y(cur_w, stim[j]);
      checks++;
      if (got[j] !== exp_y) begin
        errors++; $display("FAIL persist_y%0d: got %h want %h", j, got[j], exp_y);
      end
    end
  endtask

  task automatic test_wlast_err();
    yvec_t exp_y;
    apply_reset();
    load_weights(rand_w(), 1);
    checks++; if (load_ok !== 1'b1) begin errors++; $display("FAIL wl_beats: got %b want 1", load_ok); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wl_err: got %b want 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wl_busy: got %b want 0", busy); end
    for (int j = 0; j < 3; j++) stim[j] = rand_a();
    run_job(3, 0, 0, 0);
    checks++; if (n_got !== 3) begin errors++; $display("FAIL wl_count: got %0d want 3", n_got); end
    for (int j = 0; j < 3; j++) begin
      exp_y = model_y(cur_w, stim[j]);
      checks++;
      if (got[j] !== exp_y) begin
        errors++; $display("FAIL wl_y%0d: got %h want %h", j, got[j], exp_y);
      end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wl_sticky: got %b want 1", err); end
    apply_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wl_clear: got %b want 0", err); end
  endtask

  task automatic test_reset_midstream();
    int waited, seen, ardy_hi;
    load_weights(rand_w(), R - 1);
    a_valid = 1; a_last = 0; a_vec = rand_a();
    waited = 0;
    while (!busy && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_stream_entry: got %b want 1", busy); end
    repeat (3) begin
      @(posedge clk); #1;
      a_vec = rand_a();
    end
    #2 reset = 1'b0;
    #1;
    checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL mid_w_ready: got %b want 0", w_ready); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL mid_a_ready: got %b want 0", a_ready); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL mid_y_valid: got %b want 0", y_valid); end
    checks++; if (y_vec !== '0) begin errors++; $display("FAIL mid_y_vec: got %h want 0", y_vec); end
    checks++; if (y_last !== 1'b0) begin errors++; $display("FAIL mid_y_last: got %b want 0", y_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", err); end
    a_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    count_valid(15, seen);
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_ghost_y: got %0d want 0", seen); end
    a_valid = 1; a_last = 1; ardy_hi = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_ready) ardy_hi++;
      @(posedge clk); #1;
    end
    a_valid = 0; a_last = 0;
    checks++; if (ardy_hi !== 0) begin errors++; $display("FAIL mid_noload_a_ready: got %0d want 0", ardy_hi); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mid_noload_err: got %b want 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_noload_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_back_to_back();
    test_backpressure();
    test_bubbles_persist();
    test_wlast_err();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_array_ws.md
SYSTOLIC_ARRAY_WS -- requirements
Module: systolic_array_ws

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning PE rows (reduction depth, K), minimum 2.
REQ-002 SHALL have parameter COLS, default 4, meaning PE columns (output vector width, N), minimum 2.
REQ-003 SHALL have parameter DATA_W, default 16, meaning signed width of weight and activation operands.
REQ-004 SHALL have parameter ACC_W, default 2*DATA_W+$clog2(ROWS), meaning signed accumulator/result width.
REQ-005 SHALL have clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port w_valid / w_ready  in / out  1 / 1  weight-row beat handshake.
REQ-009 SHALL have port w_row  in  COLS x DATA_W  row k of W, as W[k][0..COLS-1].
REQ-010 SHALL have port w_last  in  1  marks the final weight beat.
REQ-011 SHALL have port a_valid / a_ready  in / out  1 / 1  activation-vector handshake.
REQ-012 SHALL have port a_vec  in  ROWS x DATA_W  one activation row, as A[t][0..ROWS-1].
REQ-013 SHALL have port a_last  in  1  marks the final activation vector of a job.
REQ-014 SHALL have port y_valid / y_ready  out / in  1 / 1  result handshake.
REQ-015 SHALL have port y_vec / y_last  out  COLS x ACC_W / 1  Y[t][c]; y_last accompanies the result of the a_last input.
REQ-016 SHALL have port busy / err  out  1 / 1  state != IDLE / sticky protocol error.

Function
REQ-017 SHALL compute Y[t][c] = sum over r of A[t][r]*W[r][c], signed two's complement, full-precision products, with sums wrapping modulo 2^ACC_W.
REQ-018 SHALL be weight-stationary: each PE(r,c) holds W[r][c], passes activations right and partial sums down, using input skew and output deskew registers internally.
REQ-019 SHALL use FSM states IDLE, LOAD_W, STREAM and DRAIN.
REQ-020 IDLE SHALL go to LOAD_W on w_valid, or to STREAM on a_valid when weights_loaded=1; w_valid SHALL win if both are high.
REQ-021 In LOAD_W, w_ready=1; beat k (0..ROWS-1) SHALL write PE row k; after beat ROWS-1, weights_loaded SHALL be set and the FSM SHALL return to IDLE.
REQ-022 A w_last whose position does not match beat ROWS-1 SHALL set err; the beat count alone SHALL terminate loading.
REQ-023 An a_valid in IDLE with weights_loaded=0 SHALL set err, and a_ready SHALL stay 0.
REQ-024 Global advance: adv = !(y_valid && !y_ready); every pipeline, skew and deskew register SHALL update only when adv=1.
REQ-025 In STREAM, a_ready SHALL equal adv; in all other states a_ready SHALL be 0, and w_ready SHALL be 0 outside LOAD_W.
REQ-026 A valid bit SHALL travel with each accepted vector; bubbles (a_valid=0) SHALL produce no y_valid.
REQ-027 Latency SHALL be exactly ROWS+COLS cycles from the a_valid&&a_ready edge to y_valid, with adv held at 1, and results SHALL appear in input order.
REQ-028 The FSM SHALL go STREAM to DRAIN on an accepted a_last, and DRAIN to IDLE on the y_valid&&y_ready&&y_last transfer.
REQ-029 While y_valid=1 and y_ready=0, y_vec and y_last SHALL hold stable.
REQ-030 Weights SHALL persist across jobs until reloaded or reset.

Reset
REQ-031 Asserted reset SHALL immediately clear all outputs to 0 (w_ready, a_ready, y_valid, y_vec, y_last, busy, err).
REQ-032 Asserted reset SHALL force state to IDLE, clear weights_loaded, weights, pipeline valid bits and the beat counter.
REQ-033 Reset mid-job SHALL discard in-flight results, with no y_valid after release until a new job.

Structure
REQ-034 Package systolic_pkg SHALL hold the FSM state enum and the default ACC_W helper function.
REQ-035 Sub-module ws_pe SHALL provide a weight register, multiply-add, and registered data/sum outputs with enable; the top SHALL instantiate it ROWS x COLS times in generate loops.

Verification (ROWS=COLS=4, DATA_W=16)
REQ-036 W=identity, A=[1,2,3,4], y_ready=1 -> y_vec=[1,2,3,4], y_last=1, y_valid exactly 8 cycles after acceptance.
REQ-037 W all 2, three back-to-back vectors [1,1,1,1], [-1,0,0,0], [32767,32767,0,0] -> y_vec [8,8,8,8], [-2,-2,-2,-2], [131068 x4] in order.
REQ-038 y_ready=0 for 5 cycles mid-stream -> y_vec stable, a_ready=0, no loss or duplication, and the resumed sequence is correct.
REQ-039 w_last on beat 1 -> err=1; loading completes after 4 beats; err stays 1 until reset.
REQ-040 Reset asserted 3 cycles into STREAM -> outputs 0 immediately; after release, a_valid with no reload -> err=1 and a_ready=0.
